// File: rtl/mem_io_bridge.sv
// CPU data-bus bridge: word RAM, switch/LED registers and a
// multiplexed 8-digit 7-segment display driver.
module mem_io_bridge #(
   parameter int SCAN_DIV  = 100000,
   parameter int RAM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] aluout,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [15:0] sw,
   output logic [15:0] led,
   output logic [7:0]  an,
   output logic [6:0]  seg
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [29:0]   waddr;
   logic [AW-1:0] ram_idx;
   logic          sel_ram, sel_status, sel_switch, sel_led, sel_seg;
   logic          ram_we;
   logic [1:0]    unused_addr;

   logic [31:0]   ram_q [RAM_WORDS];

   logic [15:0]   led_q, led_d;
   logic [31:0]   segreg_q, segreg_d;
   logic          sw_chg_q, sw_chg_d;
   logic [15:0]   sw_meta_q, sw_sync_q, sw_prev_q;
   logic [CW-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]    dsel_q, dsel_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   assign unused_addr = aluout[1:0];
   assign waddr       = aluout[31:2];
   assign ram_idx     = aluout[AW+1:2];
   assign sel_ram     = waddr < 30'(RAM_WORDS);
   assign sel_status  = waddr == 30'h3FC0;
   assign sel_switch  = waddr == 30'h3FC1;
   assign sel_led     = waddr == 30'h3FC2;
   assign sel_seg     = waddr == 30'h3FC3;

   // RAM is unreset; a write landing while reset is held is dropped
   assign ram_we = memwrite & sel_ram & reset;

   always_ff @(posedge clk) begin
      if (ram_we) ram_q[ram_idx] <= writedata;
   end

   always_comb begin
      readdata = '0;
      unique case (1'b1)
         sel_ram:    readdata = ram_q[ram_idx];
         sel_status: readdata = {31'b0, sw_chg_q};
         sel_switch: readdata = {16'b0, sw_sync_q};
         sel_led:    readdata = {16'b0, led_q};
         sel_seg:    readdata = segreg_q;
         default:    readdata = '0;
      endcase
   end

   always_comb begin
      led_d      = led_q;
      segreg_d   = segreg_q;
      sw_chg_d   = sw_chg_q;
      scan_cnt_d = scan_cnt_q + CW'(1);
      dsel_d     = dsel_q;
      if (memwrite && sel_led)    led_d    = writedata[15:0];
      if (memwrite && sel_seg)    segreg_d = writedata;
      if (memwrite && sel_status) sw_chg_d = 1'b0;
      if (sw_sync_q != sw_prev_q) sw_chg_d = 1'b1;
      if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         dsel_d     = dsel_q + 3'd1;
      end
      // decode from next-state values so a SEGREG write shows at once
      an_d  = ~(8'b1 << dsel_d);
      seg_d = hex7(segreg_d[{dsel_d, 2'b00} +: 4]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q      <= '0;
         segreg_q   <= '0;
         sw_chg_q   <= 1'b0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         sw_prev_q  <= '0;
         scan_cnt_q <= '0;
         dsel_q     <= '0;
         an_q       <= 8'hFE;
         seg_q      <= 7'b1000000;
      end else begin
         led_q      <= led_d;
         segreg_q   <= segreg_d;
         sw_chg_q   <= sw_chg_d;
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         sw_prev_q  <= sw_sync_q;
         scan_cnt_q <= scan_cnt_d;
         dsel_q     <= dsel_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign led = led_q;
   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: stimulus queues expected
// values, a negedge monitor pops and compares them.
module tb_mem_io_bridge;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] aluout;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [15:0] sw;
   logic [15:0] led;
   logic [7:0]  an;
   logic [6:0]  seg;

   mem_io_bridge #(
      .SCAN_DIV (4),
      .RAM_WORDS(64)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .memwrite (memwrite),
      .aluout   (aluout),
      .writedata(writedata),
      .readdata (readdata),
      .sw       (sw),
      .led      (led),
      .an       (an),
      .seg      (seg)
   );

   typedef struct {
      logic [31:0] v;
      int          sel;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] act;
   logic        obs_valid;
   logic        done;
   int          n_vec;
   int          n_bad;

   logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pick(input int s);
      case (s)
         0: pick = readdata;
         1: pick = {16'b0, led};
         2: pick = {17'b0, an, seg};
         3: pick = {25'b0, seg};
         4: pick = {1'b0, led, an, seg};
         default: pick = '0;
      endcase
   endfunction

   task automatic push(input int sel, input logic [31:0] v,
                       input string name);
      exp_t x;
      x.v    = v;
      x.sel  = sel;
      x.name = name;
      exp_q.push_back(x);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      memwrite  = 1'b0;
      obs_valid = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      memwrite  = 1'b1;
      aluout    = a;
      writedata = d;
      obs_valid = 1'b0;
   endtask

   task automatic chk(input int sel, input logic [31:0] a,
                      input logic [31:0] v, input string name);
      @(posedge clk);
      #1;
      memwrite  = 1'b0;
      aluout    = a;
      push(sel, v, name);
      obs_valid = 1'b1;
   endtask

   always @(negedge clk) begin
      if (obs_valid) begin
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: observation with empty queue");
         end else begin
            e   = exp_q.pop_front();
            act = pick(e.sel);
            n_vec++;
            if (act !== e.v) begin
               n_bad++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.v);
            end
         end
      end
      if (done) begin
         if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d unchecked, expected 0",
                     exp_q.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==",
                  n_vec, n_bad);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      done      = 1'b0;
      obs_valid = 1'b0;
      reset     = 1'b0;
      memwrite  = 1'b0;
      aluout    = '0;
      writedata = '0;
      sw        = '0;

      chk(4, 32'h0, {1'b0, 16'h0, 8'hFE, 7'b1000000}, "reset_out");
      chk(0, 32'hFF00, 32'h0, "reset_status");
      chk(0, 32'hFF0C, 32'h0, "reset_segreg");
      chk(0, 32'hFF04, 32'h0, "reset_switch");
      @(posedge clk);
      #1;
      reset     = 1'b1;
      obs_valid = 1'b0;

      wr(32'h04, 32'hDEADBEEF);
      wr(32'hFC, 32'h12345678);
      wr(32'h00, 32'h11111111);
      chk(0, 32'h04, 32'hDEADBEEF, "ram_rd_04");
      chk(0, 32'hFC, 32'h12345678, "ram_rd_fc");
      chk(0, 32'h07, 32'hDEADBEEF, "ram_rd_07");
      chk(0, 32'h100, 32'h0, "ram_past_end");

      wr(32'hFF08, 32'h0001A5A5);
      chk(1, 32'h0, 32'h0000A5A5, "led_out");
      chk(0, 32'hFF08, 32'h0000A5A5, "led_rd");
      wr(32'hFF04, 32'hFFFFFFFF);
      chk(0, 32'hFF04, 32'h0, "switch_ro");
      chk(1, 32'h0, 32'h0000A5A5, "led_keep");
      wr(32'h1000, 32'hBAD0BAD0);
      chk(0, 32'h1000, 32'h0, "unmapped_rd");
      chk(0, 32'h0, 32'h11111111, "ram0_keep");

      wr(32'hFF0C, 32'hFFFFFFFF);
      chk(3, 32'h0, {25'b0, 7'b0001110}, "seg_immediate");
      chk(0, 32'hFF0C, 32'hFFFFFFFF, "segreg_rd");

      @(posedge clk);
      #1;
      sw        = 16'h00F0;
      memwrite  = 1'b0;
      obs_valid = 1'b0;
      cyc();
      cyc();
      chk(0, 32'hFF04, 32'h000000F0, "sw_sync");
      chk(0, 32'hFF00, 32'h1, "sw_chg_set");
      wr(32'hFF00, 32'h0);
      chk(0, 32'hFF00, 32'h0, "sw_chg_clear");

      @(posedge clk);
      #1;
      sw        = 16'h000F;
      memwrite  = 1'b0;
      obs_valid = 1'b0;
      cyc();
      wr(32'hFF00, 32'h0);
      chk(0, 32'hFF00, 32'h1, "sw_chg_race");
      chk(0, 32'hFF04, 32'h0000000F, "sw_sync2");

      wr(32'hFF08, 32'h0000FFFF);
      chk(1, 32'h0, 32'h0000FFFF, "led_ffff");
      cyc();
      @(posedge clk);
      #1;
      memwrite  = 1'b1;
      aluout    = 32'hFF08;
      writedata = 32'h00001234;
      #2;
      reset = 1'b0;
      push(4, {1'b0, 16'h0, 8'hFE, 7'b1000000}, "async_reset");
      obs_valid = 1'b1;
      chk(0, 32'hFF08, 32'h0, "led_rd_in_reset");
      chk(0, 32'hFF00, 32'h0, "chg_in_reset");

      @(posedge clk);
      #1;
      reset     = 1'b1;
      memwrite  = 1'b1;
      aluout    = 32'hFF0C;
      writedata = 32'h76543210;
      obs_valid = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         automatic int d = (k / 4) % 8;
         logic [7:0] an_x;
         an_x = ~(8'b1 << d);
         chk(2, 32'h0, {17'b0, an_x, seg_tab[d]},
             $sformatf("scan_k%0d", k));
      end
      chk(0, 32'hFF0C, 32'h76543210, "segreg_after_scan");

      cyc();
      done = 1'b1;
      cyc();
      cyc();
   end

endmodule
